// File: rtl/hawk_pkg.sv
// Shared Hawk drive definitions: geometry limits, seek FSM encoding and address check.
// Used by hawk_drive_model and the DSK-side command generator.
package hawk_pkg;

  localparam int unsigned HAWK_MAX_CYL = 407;
  localparam int unsigned HAWK_SECTORS = 16;
  localparam int unsigned HAWK_CYL_W   = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SETTLE = 2'd2,
    ERROR  = 2'd3
  } hawk_seek_state_t;

  function automatic logic hawk_cyl_legal(input logic [HAWK_CYL_W-1:0] cyl);
    return (cyl <= 9'(HAWK_MAX_CYL));
  endfunction

endpackage

// File: rtl/hawk_rotation.sv
// Free-running platter rotation: sector counter, sector/index pulses and sector address.
// The sector address is loaded on the same edge the pulse rises so it is stable across it.
module hawk_rotation
  import hawk_pkg::*;
#(
  parameter int unsigned CLK_PER_SECTOR   = 62500,
  parameter int unsigned SECTOR_PULSE_LEN = 40
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hawk_sector,
  output logic       hawk_index,
  output logic [4:0] hawk_sa
);

  localparam int unsigned CW = (CLK_PER_SECTOR > 1) ? $clog2(CLK_PER_SECTOR) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_SECTOR - 1);
  localparam logic [CW-1:0] PULSE_END = CW'(SECTOR_PULSE_LEN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_secnum;
  logic          r_sector;
  logic          r_index;
  logic [4:0]    r_sa;

  // Rotation counter, sector number and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_secnum <= 4'd0;
      r_sector <= 1'b0;
      r_index  <= 1'b0;
      r_sa     <= 5'd0;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_secnum <= r_secnum + 4'd1;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (r_cnt == '0) begin
        r_sector <= 1'b1;
        r_index  <= (r_secnum == 4'd0);
        r_sa     <= {1'b0, r_secnum};
      end else if (r_cnt == PULSE_END) begin
        r_sector <= 1'b0;
        r_index  <= 1'b0;
      end else begin
        r_sector <= r_sector;
        r_index  <= r_index;
      end
    end
  end

  assign hawk_sector = r_sector;
  assign hawk_index  = r_index;
  assign hawk_sa     = r_sa;

endmodule

// File: rtl/hawk_drive_model.sv
// Hawk drive mechanical model: seek/settle/RTZ FSM plus free-running rotation.
// Define HAWK_SEEK_TIMING_EN for per-cylinder step and settle timing; otherwise seeks take 1+1 clocks.
module hawk_drive_model
  import hawk_pkg::*;
#(
  parameter int unsigned CLK_PER_SECTOR   = 62500,
  parameter int unsigned SECTOR_PULSE_LEN = 40,
  parameter int unsigned SEEK_STEP_CLKS   = 400,
  parameter int unsigned SEEK_SETTLE_CLKS = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hawk_cyl_strobe,
  input  logic [8:0] hawk_cylad,
  input  logic       hawk_rtzs,
  output logic       hawk_ready,
  output logic       hawk_on_cyl,
  output logic       hawk_addr_ack,
  output logic       hawk_seek_err,
  output logic       hawk_sector,
  output logic       hawk_index,
  output logic [4:0] hawk_sa
);

  logic             r_strobe_s1, r_strobe_s2, r_rtz_s1, r_rtz_s2;
  logic [8:0]       r_cylad_s;
  hawk_seek_state_t r_state, w_state_nx;
  logic [8:0]       r_cyl, w_cyl_nx, r_target, w_target_nx;
  logic             r_ready, r_on_cyl, r_ack, r_err, w_ack_nx;
  logic             w_strobe_rise, w_rtz_rise;

`ifdef HAWK_SEEK_TIMING_EN
  localparam logic [31:0] STEP_LAST   = 32'(SEEK_STEP_CLKS - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SEEK_SETTLE_CLKS - 1);
  logic [31:0] r_timer, w_timer_nx;
  logic [8:0]  w_cyl_step;
  assign w_cyl_step = (r_target > r_cyl) ? (r_cyl + 9'd1) : (r_cyl - 9'd1);
`endif

  assign w_strobe_rise = r_strobe_s1 & ~r_strobe_s2;
  assign w_rtz_rise    = r_rtz_s1 & ~r_rtz_s2;

  // Input sampling for edge detection; the address is captured with the strobe sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_s1 <= 1'b0;
      r_strobe_s2 <= 1'b0;
      r_rtz_s1    <= 1'b0;
      r_rtz_s2    <= 1'b0;
      r_cylad_s   <= 9'd0;
    end else begin
      r_strobe_s1 <= hawk_cyl_strobe;
      r_strobe_s2 <= r_strobe_s1;
      r_rtz_s1    <= hawk_rtzs;
      r_rtz_s2    <= r_rtz_s1;
      r_cylad_s   <= hawk_cylad;
    end
  end

  // Seek FSM next state; RTZ overrides everything, including a same-cycle strobe
  always_comb begin
    w_state_nx  = r_state;
    w_cyl_nx    = r_cyl;
    w_target_nx = r_target;
    w_ack_nx    = 1'b0;
`ifdef HAWK_SEEK_TIMING_EN
    w_timer_nx  = r_timer + 32'd1;
`endif
    if (w_rtz_rise) begin
      w_ack_nx    = 1'b1;
      w_target_nx = 9'd0;
`ifdef HAWK_SEEK_TIMING_EN
      w_timer_nx  = 32'd0;
`endif
      if (r_cyl == 9'd0) begin
        w_state_nx = SETTLE;
      end else begin
        w_state_nx = MOVE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_strobe_rise) begin
            w_ack_nx = 1'b1;
`ifdef HAWK_SEEK_TIMING_EN
            w_timer_nx = 32'd0;
`endif
            if (!hawk_cyl_legal(r_cylad_s)) begin
              w_state_nx = ERROR;
            end else if (r_cylad_s == r_cyl) begin
              w_state_nx = IDLE;
            end else begin
              w_target_nx = r_cylad_s;
              w_state_nx  = MOVE;
            end
          end else begin
            w_state_nx = IDLE;
          end
        end
        MOVE: begin
`ifdef HAWK_SEEK_TIMING_EN
          if (r_timer == STEP_LAST) begin
            w_timer_nx = 32'd0;
            w_cyl_nx   = w_cyl_step;
            if (w_cyl_step == r_target) begin
              w_state_nx = SETTLE;
            end else begin
              w_state_nx = MOVE;
            end
          end else begin
            w_state_nx = MOVE;
          end
`else
          w_cyl_nx   = r_target;
          w_state_nx = SETTLE;
`endif
        end
        SETTLE: begin
`ifdef HAWK_SEEK_TIMING_EN
          if (r_timer == SETTLE_LAST) begin
            w_state_nx = IDLE;
          end else begin
            w_state_nx = SETTLE;
          end
`else
          w_state_nx = IDLE;
`endif
        end
        ERROR:   w_state_nx = ERROR;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // State, position and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cyl    <= 9'd0;
      r_target <= 9'd0;
      r_ready  <= 1'b1;
      r_on_cyl <= 1'b1;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cyl    <= w_cyl_nx;
      r_target <= w_target_nx;
      r_ready  <= (w_state_nx == IDLE);
      r_on_cyl <= (w_state_nx == IDLE);
      r_ack    <= w_ack_nx;
      r_err    <= (w_state_nx == ERROR);
    end
  end

`ifdef HAWK_SEEK_TIMING_EN
  // Step / settle interval timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 32'd0;
    end else begin
      r_timer <= w_timer_nx;
    end
  end
`endif

  assign hawk_ready    = r_ready;
  assign hawk_on_cyl   = r_on_cyl;
  assign hawk_addr_ack = r_ack;
  assign hawk_seek_err = r_err;

  hawk_rotation #(
    .CLK_PER_SECTOR  (CLK_PER_SECTOR),
    .SECTOR_PULSE_LEN(SECTOR_PULSE_LEN)
  ) u_rotation (
    .clk        (clk),
    .rst        (rst),
    .hawk_sector(hawk_sector),
    .hawk_index (hawk_index),
    .hawk_sa    (hawk_sa)
  );

endmodule

// File: tb/tb_hawk_drive_model.sv
// Scoreboard bench for hawk_drive_model: stimulus pushes expected events, a negedge monitor pops and compares.
// Seek latencies follow HAWK_SEEK_TIMING_EN when it is defined for the build.
module tb_hawk_drive_model;

  localparam int CPS    = 100;
  localparam int SPL    = 4;
  localparam int STEP   = 3;
  localparam int SETTLE = 5;

  typedef struct {int cyc; int sa; int idx;} sec_exp_t;
  typedef struct {int cyc; int v;} ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic       rtzs = 1'b0;
  logic [8:0] cylad = 9'd0;
  logic       hawk_ready, hawk_on_cyl, hawk_addr_ack, hawk_seek_err, hawk_sector, hawk_index;
  logic [4:0] hawk_sa;

  int checks = 0;
  int failures = 0;
  int cyc;

  int       q_ack[$];
  int       q_rf[$];
  int       q_rr[$];
  ev_t      q_err[$];
  sec_exp_t q_sec[$];

  logic p_sector, p_ready, p_err;
  int   rise_cyc;
  bit   rise_valid;

  hawk_drive_model #(
    .CLK_PER_SECTOR  (CPS),
    .SECTOR_PULSE_LEN(SPL),
    .SEEK_STEP_CLKS  (STEP),
    .SEEK_SETTLE_CLKS(SETTLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hawk_cyl_strobe(strobe),
    .hawk_cylad     (cylad),
    .hawk_rtzs      (rtzs),
    .hawk_ready     (hawk_ready),
    .hawk_on_cyl    (hawk_on_cyl),
    .hawk_addr_ack  (hawk_addr_ack),
    .hawk_seek_err  (hawk_seek_err),
    .hawk_sector    (hawk_sector),
    .hawk_index     (hawk_index),
    .hawk_sa        (hawk_sa)
  );

  always #5 clk = ~clk;

  // cyc = number of active edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rdy_lat(input int d);
`ifdef HAWK_SEEK_TIMING_EN
    return 1 + d * STEP + SETTLE;
`else
    return 3;
`endif
  endfunction

  task automatic seek(input logic [8:0] a, output int n);
    cylad  = a;
    strobe = 1'b1;
    n      = cyc + 1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT shows an ack, a sector pulse or a status change
  always @(negedge clk) begin
    int e;
    sec_exp_t s;
    ev_t ev;
    if (rst) begin
      p_sector   = hawk_sector;
      p_ready    = hawk_ready;
      p_err      = hawk_seek_err;
      rise_valid = 1'b0;
    end else begin
      if (hawk_addr_ack) begin
        chk("ack_expected", (q_ack.size() > 0) ? 1 : 0, 1);
        if (q_ack.size() > 0) begin
          e = q_ack.pop_front();
          chk("ack_cycle", cyc, e);
        end
      end
      if (hawk_sector && !p_sector && q_sec.size() > 0) begin
        s = q_sec.pop_front();
        chk("sector_rise_cycle", cyc, s.cyc);
        chk("sector_sa", int'(hawk_sa), s.sa);
        chk("sector_index", int'(hawk_index), s.idx);
        rise_cyc   = cyc;
        rise_valid = 1'b1;
      end
      if (!hawk_sector && p_sector && rise_valid) begin
        chk("sector_width", cyc - rise_cyc, SPL);
        chk("index_fall", int'(hawk_index), 0);
        rise_valid = 1'b0;
      end
      if (hawk_ready != p_ready) begin
        chk("on_cyl_tracks_ready", int'(hawk_on_cyl), int'(hawk_ready));
        if (hawk_ready) begin
          chk("ready_rise_expected", (q_rr.size() > 0) ? 1 : 0, 1);
          if (q_rr.size() > 0) begin
            e = q_rr.pop_front();
            chk("ready_rise_cycle", cyc, e);
          end
        end else begin
          chk("ready_fall_expected", (q_rf.size() > 0) ? 1 : 0, 1);
          if (q_rf.size() > 0) begin
            e = q_rf.pop_front();
            chk("ready_fall_cycle", cyc, e);
          end
        end
      end
      if (hawk_seek_err != p_err) begin
        chk("seek_err_change_expected", (q_err.size() > 0) ? 1 : 0, 1);
        if (q_err.size() > 0) begin
          ev = q_err.pop_front();
          chk("seek_err_cycle", cyc, ev.cyc);
          chk("seek_err_value", int'(hawk_seek_err), ev.v);
        end
      end
      p_sector = hawk_sector;
      p_ready  = hawk_ready;
      p_err    = hawk_seek_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, m;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(hawk_ready), 1);
    chk("rst_on_cyl", int'(hawk_on_cyl), 1);
    chk("rst_ack", int'(hawk_addr_ack), 0);
    chk("rst_seek_err", int'(hawk_seek_err), 0);
    chk("rst_sector", int'(hawk_sector), 0);
    chk("rst_index", int'(hawk_index), 0);
    chk("rst_sa", int'(hawk_sa), 0);

    // Rotation: 17 pulses, index on sector 0 at cycles 1 and 1601
    for (int k = 0; k < 17; k++) q_sec.push_back('{1 + CPS * k, k % 16, (k % 16 == 0) ? 1 : 0});
    rst = 1'b0;
    wait_cyc(1700);
    chk("sector_all_seen", q_sec.size(), 0);

    // Seek 0 -> 10
    seek(9'd10, n);
    q_ack.push_back(n + 1); q_rf.push_back(n + 1); q_rr.push_back(n + rdy_lat(10));
    wait_cyc(n + 45);

    // Seek to current cylinder: ack only
    seek(9'd10, n);
    q_ack.push_back(n + 1);
    wait_cyc(n + 10);

    // Illegal address, ignored strobe in ERROR, then RTZ from cylinder 10
    seek(9'd450, n);
    q_ack.push_back(n + 1); q_rf.push_back(n + 1); q_err.push_back('{n + 1, 1});
    wait_cyc(n + 5);
    seek(9'd5, n2);
    wait_cyc(n2 + 5);
    rtzs = 1'b1;
    m = cyc + 1;
    q_ack.push_back(m + 1); q_err.push_back('{m + 1, 0}); q_rr.push_back(m + rdy_lat(10));
    repeat (2) @(negedge clk);
    rtzs = 1'b0;
    wait_cyc(m + 45);

    // Strobe and RTZ together during a seek to 20: RTZ wins
    seek(9'd20, n);
    q_ack.push_back(n + 1); q_rf.push_back(n + 1);
`ifndef HAWK_SEEK_TIMING_EN
    q_rr.push_back(n + 3);
`endif
    wait_cyc(n + 7);
    cylad = 9'd40; strobe = 1'b1; rtzs = 1'b1;
    m = cyc + 1;
    q_ack.push_back(m + 1);
`ifdef HAWK_SEEK_TIMING_EN
    q_rr.push_back(m + 12);
`else
    q_rf.push_back(m + 1); q_rr.push_back(m + rdy_lat(20));
`endif
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); rtzs = 1'b0;
    wait_cyc(m + 25);
    seek(9'd0, n);
    q_ack.push_back(n + 1);
    wait_cyc(n + 8);

    // Reset in the middle of a seek to 30
    seek(9'd30, n);
    q_ack.push_back(n + 1); q_rf.push_back(n + 1);
`ifndef HAWK_SEEK_TIMING_EN
    q_rr.push_back(n + 3);
`endif
    wait_cyc(n + 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q_sec.push_back('{1, 0, 1});
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(hawk_ready), 1);
    chk("post_rst_on_cyl", int'(hawk_on_cyl), 1);
    chk("post_rst_sa", int'(hawk_sa), 0);
    wait_cyc(10);
    chk("post_rst_sector_seen", q_sec.size(), 0);
    seek(9'd0, n);
    q_ack.push_back(n + 1);
    wait_cyc(n + 8);

    chk("ack_queue_empty", q_ack.size(), 0);
    chk("ready_fall_queue_empty", q_rf.size(), 0);
    chk("ready_rise_queue_empty", q_rr.size(), 0);
    chk("seek_err_queue_empty", q_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hawk_drive_model.md
# hawk_drive_model

Behavioural model of the Hawk drive's mechanical side: head positioning (seek, settle, return-to-zero) and rotational position (sector, index, sector address). It sits directly downstream of the DSK-side command generator. It consumes `hawk_cyl_strobe` / `hawk_cylad` and produces the status and timing signals that generator waits on: `hawk_ready`, `hawk_on_cyl`, `hawk_addr_ack`, `hawk_seek_err`, `hawk_sector`, `hawk_index` and `hawk_sa`. It lets the controller be exercised on an FPGA or in simulation without a physical drive.

## Interface
Parameters:
- `CLK_PER_SECTOR`, 62500: clocks per sector period (16 sectors per rev, 40 MHz, 2400 rpm).
- `SECTOR_PULSE_LEN`, 40: width of sector/index pulses in clocks; must be < `CLK_PER_SECTOR`.
- `SEEK_STEP_CLKS`, 400: clocks per cylinder moved.
- `SEEK_SETTLE_CLKS`, 4000: settle clocks after the last step.

Ports:
- `clk` in 1: sole clock; all inputs synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `hawk_cyl_strobe` in 1: seek request; acted on at its rising edge (sampled 0 then 1).
- `hawk_cylad` in 9: target cylinder, sampled with the strobe edge.
- `hawk_rtzs` in 1: return-to-zero request, level; acted on at its rising edge.
- `hawk_ready` out 1: drive idle and positioned; accepts seeks.
- `hawk_on_cyl` out 1: heads on a valid cylinder, not moving.
- `hawk_addr_ack` out 1: one-cycle pulse, seek or RTZ accepted.
- `hawk_seek_err` out 1: sticky illegal-address flag.
- `hawk_sector` out 1: sector pulse.
- `hawk_index` out 1: index pulse, coincident with the sector-0 pulse.
- `hawk_sa` out 5: current sector number; bit 4 always 0.

## Operation
- Seek FSM states:
  - IDLE: ready=1, on_cyl=1.
  - MOVE: ready=0, on_cyl=0.
  - SETTLE: ready=0, on_cyl=0.
  - ERROR: ready=0, on_cyl=0, seek_err=1.
- IDLE + strobe edge, `hawk_cylad` ≤ 407, target ≠ current cylinder:
  - Latch the target, pulse addr_ack, go to MOVE.
  - MOVE steps the current cylinder by ±1 every `SEEK_STEP_CLKS` clocks until it equals the target, then goes to SETTLE.
  - SETTLE counts `SEEK_SETTLE_CLKS`, then returns to IDLE.
- IDLE + strobe edge, target == current cylinder: pulse addr_ack and stay in IDLE; ready and on_cyl never drop.
- IDLE + strobe edge, `hawk_cylad` > 407: pulse addr_ack and go to ERROR. The current cylinder is unchanged.
- RTZ edge in any state:
  - Pulse addr_ack, clear seek_err, set target = 0.
  - Go to MOVE, or to SETTLE if the current cylinder is already 0.
- Strobe edge in MOVE, SETTLE or ERROR: ignored, no ack.
- Strobe edge and RTZ edge in the same cycle: RTZ wins.
- Cylinder arithmetic: 9-bit unsigned; the step direction comes from comparing target and current cylinder.
- Rotation runs freely and independently of the seek FSM:
  - A 0..`CLK_PER_SECTOR`-1 counter drives the sector number, which advances 0..15 and wraps to 0.
  - `hawk_sector` is high for the first `SECTOR_PULSE_LEN` clocks of each sector.
  - `hawk_index` does the same, only for sector 0.
  - `hawk_sa` updates in the same cycle the sector pulse rises, so it is stable throughout the pulse.

## Timing
- All outputs are registered.
- Reset values:
  - ready=1, on_cyl=1, addr_ack=0, seek_err=0.
  - sector=0, index=0, sa=0.
  - Current cylinder=0, FSM=IDLE, rotation counter=0.
- Reset mid-seek: the heads are treated as being at cylinder 0, and the block is ready immediately after reset is released.
- First edge after reset release: sector=1, index=1, sa=0. Each later sector pulse rises exactly `CLK_PER_SECTOR` clocks after the previous one.
- Strobe edge sampled at edge N:
  - addr_ack=1, ready=0, on_cyl=0 after edge N+1.
  - addr_ack=0 after N+2.
  - ready=1 and on_cyl=1 after edge N+1+d·`SEEK_STEP_CLKS`+`SEEK_SETTLE_CLKS`, where d = |target − current|.
- Illegal address: seek_err=1 after edge N+1. It is held until the next RTZ acceptance.

## Configuration
- `HAWK_SEEK_TIMING_EN` defined: the stepping and settle timing above apply.
- Not defined:
  - MOVE and SETTLE last 1 clock each, whatever the distance; the current cylinder jumps straight to the target.
  - ready returns at N+3.
  - Error handling and rotation are unchanged.

## Structure
- `hawk_pkg`:
  - `HAWK_MAX_CYL`=407 and `HAWK_SECTORS`=16.
  - `hawk_seek_state_t` enum (IDLE, MOVE, SETTLE, ERROR).
  - This is shared with the DSK-side command generator.
- Sub-module `hawk_rotation`: holds the rotation counter, sector number and pulse generation, with outputs `hawk_sector`, `hawk_index` and `hawk_sa`.
- Seek FSM and edge detection stay in the top module.

## Test plan
Bench parameters: `CLK_PER_SECTOR`=100, `SECTOR_PULSE_LEN`=4, `SEEK_STEP_CLKS`=3, `SEEK_SETTLE_CLKS`=5, macro defined.
- Release reset, run 1700 clocks → sector pulses at cycles 1, 101, 201…, each 4 clocks wide; sa sequence 0..15 then 0 again; index high only in cycles 1–4 and 1601–1604.
- From cylinder 0, strobe with cylad=10 at edge N → addr_ack pulses at N+1; ready and on_cyl are low until they rise at N+36.
- In IDLE at cylinder 10, strobe with cylad=10 → a single addr_ack pulse; ready and on_cyl stay 1 throughout.
- Strobe with cylad=450 → seek_err=1 and ready=0 from N+1; a second strobe gets no ack. Then pulse rtzs → ack, seek_err=0, ready=1 at 10·3+5 clocks after the ack.
- During MOVE, apply a strobe and rtzs together → RTZ taken; the heads end at cylinder 0.
- Assert rst mid-MOVE for 2 clocks → ready=1, on_cyl=1, sa=0 after release, and a sector pulse on the first edge after release.
